mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the pipelined MIPS core.
- Data-side requests come from the MEM stage: MemR/MemW from the control unit, with the ALU result as address.
- Serialises the two requesters, sequences each multi-cycle memory access, and returns read data per port.
- Drives a global pipeline stall until every active request in the current pipeline cycle has been served.

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundle of every handshake and bus signal around the unified-memory arbiter.
//   IF port  : if_req, if_addr   -> if_rdata, if_done
//   MEM port : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_done
//   pipeline : stall
//   memory   : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
// Modports:
//   slave  - the arbiter's view.
//   master - the pipeline plus memory environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_done, dm_rdata, dm_done, stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_done, dm_rdata, dm_done, stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, fixed-latency memory between the IF stage and the
// MEM stage of the pipeline. Requests are served one at a time, data side
// first. Each access is one grant cycle followed by MEM_LAT strobe cycles.
// The pipeline is stalled until every request of the current pipeline cycle
// has its done flag set.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset; aborts any access in flight
//   bus  - mem_port_arbiter_if.slave (IF port, MEM port, stall, memory bus)
// Parameters:
//   ADDR_W, DATA_W - address and data widths (must match the interface)
//   MEM_LAT        - cycles mem_en is held per access, 1..15
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              gnt_dm_reg;     // 0 = IF owns the access, 1 = MEM port
  logic              mem_en_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] dm_rdata_reg;
  logic              if_done_reg;
  logic              dm_done_reg;

  logic              stall;
  logic              dm_elig;
  logic              if_elig;

  // A port whose done flag is already set is never granted again; this keeps
  // a MEM-stage instruction frozen behind a fetch from touching memory twice.
  assign dm_elig = bus.dm_req & ~dm_done_reg;
  assign if_elig = bus.if_req & ~if_done_reg;
  assign stall   = dm_elig | if_elig;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      gnt_dm_reg    <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
      if_done_reg   <= 1'b0;
      dm_done_reg   <= 1'b0;
    end else begin
      // Pipeline advances on this edge: the flags belong to the old cycle.
      // A completion later in this block overrides the clear, so a request
      // dropped mid-access still shows its done pulse for one cycle.
      if (!stall) begin
        if_done_reg <= 1'b0;
        dm_done_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (dm_elig) begin
            state_reg     <= ACCESS;
            gnt_dm_reg    <= 1'b1;
            cnt_reg       <= CNT_INIT;
            mem_en_reg    <= 1'b1;
            mem_we_reg    <= bus.dm_we;
            mem_addr_reg  <= bus.dm_addr;
            mem_wdata_reg <= bus.dm_wdata;
          end else if (if_elig) begin
            state_reg     <= ACCESS;
            gnt_dm_reg    <= 1'b0;
            cnt_reg       <= CNT_INIT;
            mem_en_reg    <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= bus.if_addr;
          end
        end

        ACCESS: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            state_reg  <= IDLE;
            mem_en_reg <= 1'b0;
            mem_we_reg <= 1'b0;
            if (gnt_dm_reg) begin
              dm_done_reg <= 1'b1;
              if (!mem_we_reg) begin
                dm_rdata_reg <= bus.mem_rdata;
              end
            end else begin
              if_done_reg  <= 1'b1;
              if_rdata_reg <= bus.mem_rdata;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.stall     = stall;
  assign bus.if_done   = if_done_reg;
  assign bus.dm_done   = dm_done_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.dm_rdata  = dm_rdata_reg;
  assign bus.mem_en    = mem_en_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. The bench plays both the pipeline
// (issuing one pipeline cycle's worth of requests and holding them until stall
// drops) and the memory (a small word array whose read data is only correct in
// the last strobe cycle). Expected results come from a transaction-level
// model: a shadow memory, the rule "data side first, then fetch", and the
// stall length (MEM_LAT+1) per served request.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- memory device ----------------
  logic [31:0] dev_mem [16];
  logic [31:0] ref_mem [16];
  int          en_run = 0;   // strobe cycles already completed in this run

  always @(posedge clk) begin
    if (bus.mem_en) begin
      en_run <= en_run + 1;
      if (bus.mem_we) dev_mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end else begin
      en_run <= 0;
    end
  end

  // Only the last strobe cycle carries the true word; earlier cycles carry
  // its complement so an early capture is visible.
  always_comb begin
    bus.mem_rdata = ~dev_mem[bus.mem_addr[5:2]];
    if (bus.mem_en && en_run == MEM_LAT - 1) bus.mem_rdata = dev_mem[bus.mem_addr[5:2]];
  end

  // ---------------- access monitor ----------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          len;
  } acc_t;

  acc_t acc_log[$];
  acc_t cur;
  bit   in_run = 0;

  always @(negedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (!in_run) begin
        in_run    = 1;
        cur.addr  = bus.mem_addr;
        cur.we    = bus.mem_we;
        cur.wdata = bus.mem_wdata;
        cur.len   = 1;
      end else begin
        cur.len++;
        // Bus must hold steady for the whole access; poison the length if not.
        if (bus.mem_addr !== cur.addr || bus.mem_we !== cur.we || bus.mem_wdata !== cur.wdata)
          cur.len = -1000;
      end
    end else if (in_run) begin
      in_run = 0;
      acc_log.push_back(cur);
    end
  end

  // ---------------- checking ----------------
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive the requests, hold them until stall drops, and
  // compare against the transaction-level expectation.
  task automatic run_txn(input bit ir, input logic [31:0] ia,
                         input bit dr, input bit dw, input logic [31:0] da,
                         input logic [31:0] dwd);
    int   cycles;
    int   n;
    acc_t e;
    @(negedge clk);
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.dm_req   = dr;
    bus.dm_we    = dw;
    bus.dm_addr  = da;
    bus.dm_wdata = dwd;
    #1;
    check("done_clear_if", bus.if_done, 1'b0);
    check("done_clear_dm", bus.dm_done, 1'b0);

    // Model: data side is served before the fetch.
    n = int'(ir) + int'(dr);
    if (dr) begin
      if (dw) ref_mem[da[5:2]] = dwd;
      else    exp_dm_rdata     = ref_mem[da[5:2]];
    end
    if (ir) exp_if_rdata = ref_mem[ia[5:2]];

    cycles = 0;
    while (bus.stall === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", cycles, n * (MEM_LAT + 1));
    check("if_done", bus.if_done, ir);
    check("dm_done", bus.dm_done, dr);
    check("if_rdata", bus.if_rdata, exp_if_rdata);
    check("dm_rdata", bus.dm_rdata, exp_dm_rdata);

    check("acc_count", acc_log.size(), n);
    if (dr && acc_log.size() > 0) begin
      e = acc_log.pop_front();
      check("dm_acc_addr", e.addr, da);
      check("dm_acc_we", e.we, dw);
      if (dw) check("dm_acc_wdata", e.wdata, dwd);
      check("dm_acc_len", e.len, MEM_LAT);
    end
    if (ir && acc_log.size() > 0) begin
      e = acc_log.pop_front();
      check("if_acc_addr", e.addr, ia);
      check("if_acc_we", e.we, 1'b0);
      check("if_acc_len", e.len, MEM_LAT);
    end
    acc_log.delete();
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      dev_mem[i] = v;
      ref_mem[i] = v;
    end
    dev_mem[0] = 32'h2008_0005; ref_mem[0] = 32'h2008_0005;
    dev_mem[9] = 32'h1234_5678; ref_mem[9] = 32'h1234_5678;

    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", bus.stall, 1'b0);
    check("rst_mem_en", bus.mem_en, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_if_done", bus.if_done, 1'b0);
    check("rst_dm_done", bus.dm_done, 1'b0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_dm_rdata", bus.dm_rdata, 32'h0);

    // Single fetch
    run_txn(1, 32'h0, 0, 0, 32'h0, 32'h0);
    check("fetch_word", bus.if_rdata, 32'h2008_0005);

    // Store and fetch together: store first, then fetch
    run_txn(1, 32'h4, 1, 1, 32'h10, 32'hDEAD_BEEF);

    // Load, then a store that must leave dm_rdata alone
    run_txn(0, 32'h0, 1, 0, 32'h24, 32'h0);
    check("load_word", bus.dm_rdata, 32'h1234_5678);
    run_txn(0, 32'h0, 1, 1, 32'h28, 32'hCAFE_F00D);
    check("store_keeps_rdata", bus.dm_rdata, 32'h1234_5678);

    // Reset in the first strobe cycle aborts the access
    @(negedge clk);
    bus.if_req = 1; bus.if_addr = 32'h8; bus.dm_req = 0;
    @(negedge clk);
    #1;
    check("abort_pre_en", bus.mem_en, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_mem_en", bus.mem_en, 1'b0);
    check("abort_if_done", bus.if_done, 1'b0);
    check("abort_dm_done", bus.dm_done, 1'b0);
    check("abort_if_rdata", bus.if_rdata, 32'h0);
    check("abort_dm_rdata", bus.dm_rdata, 32'h0);
    check("abort_stall", bus.stall, 1'b1);
    bus.if_req = 0;
    acc_log.delete();
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    run_txn(1, 32'h8, 0, 0, 32'h0, 32'h0);

    // Back-to-back fetches
    run_txn(1, 32'h0, 0, 0, 32'h0, 32'h0);
    run_txn(1, 32'h4, 0, 0, 32'h0, 32'h0);
    run_txn(1, 32'h8, 0, 0, 32'h0, 32'h0);

    // Load request dropped during the access
    @(negedge clk);
    bus.if_req = 0; bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h30;
    #1;
    check("drop_stall_grant", bus.stall, 1'b1);
    exp_dm_rdata = ref_mem[12];
    @(negedge clk);
    #1;
    check("drop_mem_en", bus.mem_en, 1'b1);
    bus.dm_req = 0;
    #1;
    check("drop_stall0", bus.stall, 1'b0);
    for (int k = 1; k < MEM_LAT; k++) begin
      @(negedge clk);
      #1;
      check("drop_stall_acc", bus.stall, 1'b0);
      check("drop_done_early", bus.dm_done, 1'b0);
      check("drop_mem_en_hold", bus.mem_en, 1'b1);
    end
    @(negedge clk);
    #1;
    check("drop_done_set", bus.dm_done, 1'b1);
    check("drop_rdata", bus.dm_rdata, exp_dm_rdata);
    check("drop_stall_done", bus.stall, 1'b0);
    check("drop_mem_en_off", bus.mem_en, 1'b0);
    @(negedge clk);
    #1;
    check("drop_done_clear", bus.dm_done, 1'b0);
    check("drop_stall_after", bus.stall, 1'b0);
    acc_log.delete();

    // Randomized pipeline cycles
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 15)) << 2, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
